spmv_lane_scheduler: RTL and testbench

SPMV_LANE_SCHEDULER -- requirements
Module: spmv_lane_scheduler

---
 rtl/spmv_lane_scheduler_if.sv | 29 ++
 rtl/spmv_lane_scheduler.sv | 154 +++++++++++++++
 tb/tb_spmv_lane_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_lane_scheduler_if.sv
// Bus bundle between the serial product stream, the lane scheduler and the
// reduction network. The master modport is the scheduler side; the slave
// modport is whatever feeds products in and drains lanes out.
interface spmv_lane_scheduler_if #(
    parameter int NETWORK_WIDTH = 6,
    parameter int IN_WIDTH      = 32,
    parameter int ID_WIDTH      = 5
);
    logic                     s_valid;
    logic                     s_ready;
    logic [ID_WIDTH-1:0]      s_id;
    logic [IN_WIDTH-1:0]      s_val;
    logic                     s_last;
    logic [NETWORK_WIDTH-1:0] m_valid;
    logic [ID_WIDTH-1:0]      m_id  [NETWORK_WIDTH];
    logic [IN_WIDTH-1:0]      m_val [NETWORK_WIDTH];
    logic [NETWORK_WIDTH-1:0] m_ready;
    logic                     busy;

    modport master (
        input  s_valid, s_id, s_val, s_last, m_ready,
        output s_ready, m_valid, m_id, m_val, busy
    );

    modport slave (
        output s_valid, s_id, s_val, s_last, m_ready,
        input  s_ready, m_valid, m_id, m_val, busy
    );
endinterface

// File: rtl/spmv_lane_scheduler.sv
// spmv_lane_scheduler: packs a serial stream of (row id, product) pairs into
// beats of NETWORK_WIDTH lanes for a reduction network. Products fill lanes
// in arrival order (lane 0 oldest); a beat is flushed when the last lane is
// written, when s_last is accepted, or (optionally) after TIMEOUT idle
// cycles with a partial beat. Each lane of a flushed beat retires
// independently on its own m_ready; the next beat starts once all are gone.
// Optional feature: define SPMV_SCHED_TIMEOUT_EN to enable the idle-timeout
// flush. Without it, partial beats wait for s_last or a full lane set.
module spmv_lane_scheduler #(
    parameter int NETWORK_WIDTH = 6,
    parameter int IN_WIDTH      = 32,
    parameter int ID_WIDTH      = 5,
    parameter int TIMEOUT       = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spmv_lane_scheduler_if.master bus
);
    localparam int CNT_W = $clog2(NETWORK_WIDTH + 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NETWORK_WIDTH-1:0] pend_q, pend_d;
    logic [ID_WIDTH-1:0]      id_q  [NETWORK_WIDTH];
    logic [IN_WIDTH-1:0]      val_q [NETWORK_WIDTH];

    logic             accept;
    logic             lane_full;
    logic             tmo_fire;
    logic [CNT_W-1:0] cnt_inc;

    // Mask with bits 0..n-1 set: the lanes that hold products of this beat.
    function automatic logic [NETWORK_WIDTH-1:0] low_mask(input logic [CNT_W-1:0] n);
        logic [NETWORK_WIDTH-1:0] m;
        for (int i = 0; i < NETWORK_WIDTH; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    assign accept    = bus.s_valid && (state_q == FILL);
    assign cnt_inc   = cnt_q + 1'b1;
    assign lane_full = (cnt_q == CNT_W'(NETWORK_WIDTH - 1));

`ifdef SPMV_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 2);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Count idle FILL cycles while a partial beat is waiting; fire at TIMEOUT.
    always_comb begin
        tmo_d    = '0;
        tmo_fire = 1'b0;
        if ((state_q == FILL) && !accept && (cnt_q != '0)) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_W'(TIMEOUT)) begin
                tmo_fire = 1'b1;
            end
        end
    end

    // Idle counter register; cleared on accept, empty buffer, DRAIN or fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_fire ? '0 : tmo_d;
        end
    end
`else
    // No idle flush in this build. TIMEOUT is folded into a constant-false
    // term so the parameter keeps the same declaration in both builds.
    localparam bit TMO_NEVER = (TIMEOUT < 0) && 1'b0;

    assign tmo_fire = TMO_NEVER;
`endif

    // Next-state logic: fill lanes, decide when to flush, retire drained lanes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (lane_full || bus.s_last) begin
                        state_d = DRAIN;
                        pend_d  = low_mask(cnt_inc);
                    end
                end else if (tmo_fire) begin
                    state_d = DRAIN;
                    pend_d  = low_mask(cnt_q);
                end
            end
            DRAIN: begin
                pend_d = pend_q & ~bus.m_ready;
                if (pend_d == '0) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
                pend_d  = '0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Lane payload registers; only the lane addressed by the fill count loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NETWORK_WIDTH; i++) begin
                id_q[i]  <= '0;
                val_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NETWORK_WIDTH; i++) begin
                if (accept && (cnt_q == CNT_W'(i))) begin
                    id_q[i]  <= bus.s_id;
                    val_q[i] <= bus.s_val;
                end
            end
        end
    end

    assign bus.s_ready = (state_q == FILL);
    assign bus.m_valid = (state_q == DRAIN) ? pend_q : '0;
    assign bus.busy    = (state_q == DRAIN) || (cnt_q != '0);

    for (genvar g = 0; g < NETWORK_WIDTH; g++) begin : g_lane_out
        assign bus.m_id[g]  = id_q[g];
        assign bus.m_val[g] = val_q[g];
    end
endmodule

// File: tb/tb_spmv_lane_scheduler.sv
// Bench for spmv_lane_scheduler: directed table of per-cycle vectors, a few
// multi-cycle corner sequences (timeout, reset mid-drain) and a randomized
// run checked against a queue-based beat model.
module tb_spmv_lane_scheduler;
    localparam int NW  = 6;
    localparam int INW = 32;
    localparam int IDW = 5;
    localparam int TMO = 15;
`ifdef SPMV_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    spmv_lane_scheduler_if #(.NETWORK_WIDTH(NW), .IN_WIDTH(INW), .ID_WIDTH(IDW)) bus ();

    spmv_lane_scheduler #(
        .NETWORK_WIDTH(NW), .IN_WIDTH(INW), .ID_WIDTH(IDW), .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          sv;
        logic [IDW-1:0] id;
        logic          last;
        logic [NW-1:0] mr;
        logic          esr;
        logic [NW-1:0] emv;
        logic          ebusy;
        int            idb;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [INW-1:0] val;
    } prod_t;

    vec_t tbl[$];

    function automatic logic [INW-1:0] val_of(input logic [IDW-1:0] id);
        return 32'hC0DE_0000 | {27'd0, id};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sv, input logic [IDW-1:0] id, input logic last,
                         input logic [NW-1:0] mr);
        bus.s_valid = sv;
        bus.s_id    = id;
        bus.s_val   = val_of(id);
        bus.s_last  = last;
        bus.m_ready = mr;
    endtask

    task automatic add(input logic sv, input int id, input logic last, input logic [NW-1:0] mr,
                       input logic esr, input logic [NW-1:0] emv, input logic ebusy, input int idb);
        vec_t v;
        v.sv = sv; v.id = IDW'(id); v.last = last; v.mr = mr;
        v.esr = esr; v.emv = emv; v.ebusy = ebusy; v.idb = idb;
        tbl.push_back(v);
    endtask

    // Clock-edge helper: advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_lanes(input string tag, input logic [NW-1:0] mask, input int idb);
        for (int i = 0; i < NW; i++) begin
            if (mask[i]) begin
                chk({tag, "_id"}, 64'(bus.m_id[i]), 64'(idb + i));
                chk({tag, "_val"}, 64'(bus.m_val[i]), 64'(val_of(IDW'(idb + i))));
            end
        end
    endtask

    // Behavioural model state for the random phase.
    prod_t fillq[$];
    prod_t beat[NW];
    bit    pend[NW];
    bit    draining;
    int    idle;

    task automatic model_check();
        logic [NW-1:0] emv;
        for (int i = 0; i < NW; i++) emv[i] = draining && pend[i];
        chk("rnd_s_ready", 64'(bus.s_ready), 64'(!draining));
        chk("rnd_m_valid", 64'(bus.m_valid), 64'(emv));
        chk("rnd_busy", 64'(bus.busy), 64'(draining || (fillq.size() > 0)));
        for (int i = 0; i < NW; i++) begin
            if (emv[i]) begin
                chk("rnd_m_id", 64'(bus.m_id[i]), 64'(beat[i].id));
                chk("rnd_m_val", 64'(bus.m_val[i]), 64'(beat[i].val));
            end
        end
    endtask

    task automatic model_update();
        bit flush;
        bit any;
        prod_t p;
        flush = 1'b0;
        if (!draining) begin
            if (bus.s_valid) begin
                p.id = bus.s_id;
                p.val = bus.s_val;
                fillq.push_back(p);
                idle = 0;
                flush = (fillq.size() == NW) || bus.s_last;
            end else begin
                if (fillq.size() > 0) idle++;
                else idle = 0;
                flush = TMO_EN && (fillq.size() > 0) && (idle >= TMO);
            end
            if (flush) begin
                draining = 1'b1;
                for (int i = 0; i < NW; i++) begin
                    pend[i] = (i < fillq.size());
                    if (pend[i]) beat[i] = fillq[i];
                end
                fillq.delete();
                idle = 0;
            end
        end else begin
            any = 1'b0;
            for (int i = 0; i < NW; i++) begin
                if (pend[i] && bus.m_ready[i]) pend[i] = 1'b0;
                any |= pend[i];
            end
            if (!any) draining = 1'b0;
        end
    endtask

    initial begin
        int idle_seen;
        int idle_run;
        bit stray;
        total = 0;
        bad   = 0;

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("reset_s_ready", 64'(bus.s_ready), 64'd1);
        chk("reset_m_valid", 64'(bus.m_valid), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        step();

        // Full beat from six back-to-back products.
        for (int i = 1; i <= 6; i++) add(1, i, 0, '1, 1, '0, i > 1, 0);
        add(0, 0, 0, '1, 0, 6'b111111, 1, 1);
        add(0, 0, 0, '1, 1, 6'b000000, 0, 0);
        // Staggered lane completion; products offered during DRAIN are ignored.
        for (int i = 10; i <= 15; i++) add(1, i, 0, '1, 1, '0, i > 10, 0);
        add(1, 31, 0, 6'b000101, 0, 6'b111111, 1, 10);
        add(1, 31, 1, 6'b000101, 0, 6'b111010, 1, 10);
        add(1, 31, 0, 6'b111111, 0, 6'b111010, 1, 10);
        add(0, 0, 0, '1, 1, 6'b000000, 0, 0);
        // s_last on the third product gives a three-lane beat starting at lane 0.
        add(1, 7, 0, '1, 1, '0, 0, 0);
        add(1, 8, 0, '1, 1, '0, 1, 0);
        add(1, 9, 1, '1, 1, '0, 1, 0);
        add(0, 0, 0, '1, 0, 6'b000111, 1, 7);
        add(0, 0, 0, '1, 1, 6'b000000, 0, 0);
        // s_last on the sixth lane: one full beat, no trailing empty beat.
        for (int i = 16; i <= 21; i++) add(1, i, i == 21, '1, 1, '0, i > 16, 0);
        add(0, 0, 0, '1, 0, 6'b111111, 1, 16);
        add(0, 0, 0, '1, 1, 6'b000000, 0, 0);
        add(0, 0, 0, '1, 1, 6'b000000, 0, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].sv, tbl[k].id, tbl[k].last, tbl[k].mr);
            @(negedge clk);
            chk("tbl_s_ready", 64'(bus.s_ready), 64'(tbl[k].esr));
            chk("tbl_m_valid", 64'(bus.m_valid), 64'(tbl[k].emv));
            chk("tbl_busy", 64'(bus.busy), 64'(tbl[k].ebusy));
            if (tbl[k].idb > 0) check_lanes("tbl_lane", tbl[k].emv, tbl[k].idb);
            step();
        end

        // Two products then idle: timeout flush or indefinite wait.
        drive(1'b1, 5'd3, 1'b0, '1);
        step();
        drive(1'b1, 5'd4, 1'b0, '1);
        step();
        drive(1'b0, '0, 1'b0, '1);
        if (TMO_EN) begin
            idle_seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.m_valid != '0) break;
                idle_seen++;
                step();
            end
            chk("tmo_idle_cycles", 64'(idle_seen), 64'(TMO));
            chk("tmo_m_valid", 64'(bus.m_valid), 64'b000011);
            check_lanes("tmo_lane", 6'b000011, 3);
            step();
        end else begin
            stray = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.m_valid != '0 || bus.busy !== 1'b1) stray = 1'b1;
                step();
            end
            chk("notmo_stays_idle", 64'(stray), 64'd0);
            drive(1'b1, 5'd5, 1'b1, '1);
            step();
            drive(1'b0, '0, 1'b0, '1);
            @(negedge clk);
            chk("notmo_last_m_valid", 64'(bus.m_valid), 64'b000111);
            check_lanes("notmo_lane", 6'b000111, 3);
            step();
        end
        @(negedge clk);
        chk("after_partial_m_valid", 64'(bus.m_valid), 64'd0);
        chk("after_partial_s_ready", 64'(bus.s_ready), 64'd1);
        step();

        // Reset while lanes 3..5 are still pending.
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, IDW'(i), 1'b0, '0);
            step();
        end
        drive(1'b0, '0, 1'b0, 6'b000111);
        @(negedge clk);
        chk("rst_pre_m_valid", 64'(bus.m_valid), 64'b111111);
        step();
        drive(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        chk("rst_pending_m_valid", 64'(bus.m_valid), 64'b111000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_async_busy", 64'(bus.busy), 64'd0);
        chk("rst_async_m_id", 64'(bus.m_id[3]), 64'd0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 5'd22, 1'b1, '1);
        @(negedge clk);
        chk("rst_post_s_ready", 64'(bus.s_ready), 64'd1);
        step();
        drive(1'b0, '0, 1'b0, '1);
        @(negedge clk);
        chk("rst_post_m_valid", 64'(bus.m_valid), 64'b000001);
        check_lanes("rst_post_lane", 6'b000001, 22);
        step();

        // Randomized run against the beat model.
        do_reset();
        fillq.delete();
        draining = 1'b0;
        idle = 0;
        for (int i = 0; i < NW; i++) pend[i] = 1'b0;
        idle_run = 0;
        for (int c = 0; c < 4000; c++) begin
            if (idle_run > 0) begin
                idle_run--;
                bus.s_valid = 1'b0;
            end else begin
                if ($urandom_range(99) < 2) idle_run = $urandom_range(25, 10);
                bus.s_valid = ($urandom_range(99) < 60);
            end
            bus.s_id    = IDW'($urandom);
            bus.s_val   = $urandom;
            bus.s_last  = ($urandom_range(9) == 0);
            bus.m_ready = NW'($urandom);
            @(negedge clk);
            model_check();
            model_update();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
